uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, oversampled start/data/parity/stop framing.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the bit centre.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic       par_typ,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [7:0]  p_data_nxt;
  logic        pen_q, pen_nxt, ptyp_q, ptyp_nxt;
  logic        par_bad, par_bad_nxt;
  logic        dv_nxt, pe_nxt, se_nxt;
  logic        rx_meta, rx_s;
  logic        bit_val, exp_par;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] EARLY  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] DECIDE = CW'(OVERSAMPLE / 2 + 1);
  logic v_early, v_mid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_early <= 1'b1;
      v_mid   <= 1'b1;
    end else begin
      if (cnt == EARLY) v_early <= rx_s;
      if (cnt == MID)   v_mid   <= rx_s;
    end
  end

  assign bit_val = (v_early & v_mid) | (v_early & rx_s) | (v_mid & rx_s);
`else
  localparam logic [CW-1:0] DECIDE = CW'(OVERSAMPLE / 2);
  assign bit_val = rx_s;
`endif

  assign exp_par = ptyp_q ? ^shreg : ~^shreg;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      p_data     <= '0;
      pen_q      <= 1'b0;
      ptyp_q     <= 1'b0;
      par_bad    <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      rx_meta    <= rx_in;
      rx_s       <= rx_meta;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shreg      <= shreg_nxt;
      p_data     <= p_data_nxt;
      pen_q      <= pen_nxt;
      ptyp_q     <= ptyp_nxt;
      par_bad    <= par_bad_nxt;
      data_valid <= dv_nxt;
      par_err    <= pe_nxt;
      stp_err    <= se_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    idx_nxt     = idx;
    shreg_nxt   = shreg;
    p_data_nxt  = p_data;
    pen_nxt     = pen_q;
    ptyp_nxt    = ptyp_q;
    par_bad_nxt = par_bad;
    dv_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    se_nxt      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt   = START;
          pen_nxt     = par_en;
          ptyp_nxt    = par_typ;
          par_bad_nxt = 1'b0;
          idx_nxt     = '0;
        end
      end
      START: begin
        if (cnt == DECIDE && bit_val) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (cnt == DECIDE) shreg_nxt[idx] = bit_val;
        if (cnt == LAST) begin
          cnt_nxt = '0;
          idx_nxt = idx + 1'b1;
          if (idx == 3'd7) state_nxt = pen_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt == DECIDE) par_bad_nxt = (bit_val != exp_par);
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
        end
      end
      STOP: begin
        // Leave at the sample point so a start bit right after the stop bit is caught.
        if (cnt == DECIDE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (!bit_val)     se_nxt = 1'b1;
          else if (par_bad) pe_nxt = 1'b1;
          else begin
            dv_nxt     = 1'b1;
            p_data_nxt = shreg;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx (OVERSAMPLE=8): frames, parity, stop errors, false start, reset abort.
module tb_uart_rx;

  localparam int unsigned OS = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned EXTRA = 1;
`else
  localparam int unsigned EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, busy;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
    .stp_err(stp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;   // {data_valid, par_err, stp_err}
    logic [7:0]  data;
    int unsigned due;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          passed = 0;
  int          total = 0;
  logic [7:0]  last_good = 8'h00;
  logic        busy_seen;

  localparam logic [2:0] K_DV = 3'b100, K_PE = 3'b010, K_SE = 3'b001, K_NONE = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid || par_err || stp_err) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got dv/pe/se=%b%b%b p_data=%h at cycle %0d, none required",
                 data_valid, par_err, stp_err, p_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({data_valid, par_err, stp_err} !== e.kind || p_data !== e.data || cyc !== e.due)
          $display("FAIL frame_result: got kind=%b p_data=%h cycle=%0d, required kind=%b p_data=%h cycle=%0d",
                   {data_valid, par_err, stp_err}, p_data, cyc, e.kind, e.data, e.due);
        else
          passed++;
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, input logic [2:0] kind);
    int unsigned start;
    exp_t e;
    @(negedge clk);
    rx_in   = 1'b0;
    par_en  = pen;
    par_typ = ptyp;
    start = cyc + 1;
    if (kind != K_NONE) begin
      if (kind == K_DV) last_good = d;
      e.kind = kind;
      e.data = last_good;
      e.due  = start + (9 + pen) * OS + OS / 2 + 4 - 1 + EXTRA;
      exp_q.push_back(e);
    end
    repeat (OS) @(negedge clk);
    busy_seen = busy;
    // flip the framing controls mid-frame: the receiver must keep the latched values
    par_en  = ~pen;
    par_typ = ~ptyp;
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (OS) @(negedge clk);
    end
    if (pen) begin
      rx_in = pbit;
      repeat (OS) @(negedge clk);
    end
    rx_in = sbit;
    repeat (OS - 1) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    total++;
    if (exp_q.size() != 0)
      $display("FAIL drain_timeout: got %0d outstanding frames, required 0", exp_q.size());
    else
      passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (p_data !== 8'h00) $display("FAIL reset_p_data: got %h required 00", p_data); else passed++;
    if (data_valid !== 1'b0) $display("FAIL reset_dv: got %b required 0", data_valid); else passed++;
    if (par_err !== 1'b0) $display("FAIL reset_pe: got %b required 0", par_err); else passed++;
    if (stp_err !== 1'b0) $display("FAIL reset_se: got %b required 0", stp_err); else passed++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, K_DV);
    total++;
    if (busy_seen !== 1'b1) $display("FAIL busy_mid_frame: got %b required 1", busy_seen); else passed++;
    drain();
    total++;
    if (busy !== 1'b0) $display("FAIL busy_after_frame: got %b required 0", busy); else passed++;
  endtask

  task automatic test_parity();
    logic [7:0] d;
    d = 8'h3C;
    send_frame(d, 1'b1, 1'b0, ~^d, 1'b1, K_DV);
    drain();
    send_frame(d, 1'b1, 1'b0, ^d, 1'b1, K_PE);
    drain();
    d = 8'h07;
    send_frame(d, 1'b1, 1'b1, ^d, 1'b1, K_DV);
    drain();
    send_frame(8'hC3, 1'b1, 1'b1, ~^(8'hC3), 1'b1, K_PE);
    drain();
    total++;
    if (p_data !== 8'h07) $display("FAIL p_data_hold: got %h required 07", p_data); else passed++;
  endtask

  task automatic test_stop_err();
    logic [7:0] d;
    d = 8'h55;
    send_frame(d, 1'b1, 1'b0, ^d, 1'b0, K_SE);
    drain();
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, K_SE);
    drain();
  endtask

  task automatic test_false_start();
    @(negedge clk);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL false_start_busy_hi: got %b required 1", busy); else passed++;
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL false_start_busy_lo: got %b required 0", busy); else passed++;
    drain();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, K_DV);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, K_DV);
    drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rx_in = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b1;
      repeat (OS) @(negedge clk);
    end
    rx_in = 1'b0;
    repeat (OS / 2) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL busy_before_abort: got %b required 1", busy); else passed++;
    rst = 1'b0;
    #1;
    total += 3;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %b required 0", busy); else passed++;
    if (p_data !== 8'h00) $display("FAIL abort_p_data: got %h required 00", p_data); else passed++;
    if ({data_valid, par_err, stp_err} !== 3'b000)
      $display("FAIL abort_pulses: got %b required 000", {data_valid, par_err, stp_err});
    else passed++;
    last_good = 8'h00;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, K_DV);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_false_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1);
  end

endmodule
